// File: rtl/wb_ic_pkg.sv
// wb_ic_pkg: state encoding and small helpers shared by the round-robin Wishbone interconnect.
package wb_ic_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  function automatic int clog2(input int unsigned v);
    int r;
    r = 0;
    while ((32'd1 << r) < v) r++;
    return r;
  endfunction

  // A slave index is mapped when it addresses one of the populated slave ports.
  function automatic logic dec_mapped(input int unsigned idx, input int unsigned num_s);
    return idx < num_s;
  endfunction

endpackage

// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter: combinational round-robin pick of the first requester at or after ptr, wrapping upward.
module wb_rr_arbiter #(
  parameter int NUM_M = 2,
  parameter int MW    = 1
) (
  input  logic [NUM_M-1:0] req,
  input  logic [MW-1:0]    ptr,
  output logic [NUM_M-1:0] gnt,
  output logic [MW-1:0]    gnt_idx,
  output logic             gnt_vld
);

  int best;
  int off;

  // Distance from ptr (with wrap) is the priority; smallest distance wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    best    = NUM_M;
    off     = 0;
    for (int k = 0; k < NUM_M; k++) begin
      off = (k + NUM_M - int'(ptr)) % NUM_M;
      if (req[k] && off < best) begin
        best    = off;
        gnt     = '0;
        gnt[k]  = 1'b1;
        gnt_idx = MW'(k);
        gnt_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_rr_interconnect.sv
// wb_rr_interconnect: NUM_M Wishbone masters arbitrated round-robin onto one shared bus decoded to NUM_S slaves.
// Unmapped addresses return err; define WB_IC_TIMEOUT_EN to add a no-acknowledge timeout.
//   state   | meaning
//   ST_IDLE | no grant, shared bus driven to 0
//   ST_BUSY | grant locked to one master until it drops cyc
module wb_rr_interconnect
  import wb_ic_pkg::*;
#(
  parameter int NUM_M       = 2,
  parameter int NUM_S       = 6,
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int DEC_W       = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_M-1:0]        m_cyc_i,
  input  logic [NUM_M-1:0]        m_stb_i,
  input  logic [NUM_M-1:0]        m_we_i,
  input  logic [NUM_M*AW-1:0]     m_adr_i,
  input  logic [NUM_M*DW-1:0]     m_dat_i,
  input  logic [NUM_M*DW/8-1:0]   m_sel_i,
  output logic [NUM_M*DW-1:0]     m_dat_o,
  output logic [NUM_M-1:0]        m_ack_o,
  output logic [NUM_M-1:0]        m_err_o,
  output logic [NUM_M-1:0]        m_rty_o,
  output logic [NUM_S-1:0]        s_cyc_o,
  output logic [NUM_S-1:0]        s_stb_o,
  output logic [NUM_S-1:0]        s_we_o,
  output logic [AW-1:0]           s_adr_o,
  output logic [DW-1:0]           s_dat_o,
  output logic [DW/8-1:0]         s_sel_o,
  input  logic [NUM_S*DW-1:0]     s_dat_i,
  input  logic [NUM_S-1:0]        s_ack_i,
  input  logic [NUM_S-1:0]        s_err_i,
  input  logic [NUM_S-1:0]        s_rty_i
);

  localparam int MW = (NUM_M > 1) ? clog2(NUM_M) : 1;
  localparam int SW = DW / 8;

  logic [0:0]       state;
  logic [NUM_M-1:0] g_oh;
  logic [MW-1:0]    rr_ptr;
  logic [MW-1:0]    rr_next;
  logic             err_q;
  logic             busy;

  logic [NUM_M-1:0] arb_gnt;
  logic [MW-1:0]    arb_idx;
  logic             arb_vld;

  logic             bus_cyc, bus_stb, bus_we;
  logic [AW-1:0]    bus_adr;
  logic [DW-1:0]    bus_dat;
  logic [SW-1:0]    bus_sel;

  logic [DEC_W-1:0] dec_idx;
  logic             mapped;
  logic             slv_ack, slv_err, slv_rty, slv_term;
  logic [DW-1:0]    slv_dat;
  logic             to_fire;

  wb_rr_arbiter #(
    .NUM_M (NUM_M),
    .MW    (MW)
  ) u_arb (
    .req     (m_cyc_i),
    .ptr     (rr_ptr),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .gnt_vld (arb_vld)
  );

  assign busy    = (state == ST_BUSY);
  assign rr_next = (arb_idx == MW'(NUM_M - 1)) ? '0 : arb_idx + MW'(1);

  always_comb begin
    bus_cyc = 1'b0;
    bus_stb = 1'b0;
    bus_we  = 1'b0;
    bus_adr = '0;
    bus_dat = '0;
    bus_sel = '0;
    for (int k = 0; k < NUM_M; k++) begin
      if (busy && g_oh[k]) begin
        bus_cyc = m_cyc_i[k];
        bus_stb = m_stb_i[k];
        bus_we  = m_we_i[k];
        bus_adr = m_adr_i[k*AW +: AW];
        bus_dat = m_dat_i[k*DW +: DW];
        bus_sel = m_sel_i[k*SW +: SW];
      end
    end
  end

  assign s_adr_o = bus_adr;
  assign s_dat_o = bus_dat;
  assign s_sel_o = bus_sel;

  assign dec_idx = bus_adr[AW-1 -: DEC_W];
  assign mapped  = dec_mapped(32'(dec_idx), NUM_S);

  always_comb begin
    slv_ack = 1'b0;
    slv_err = 1'b0;
    slv_rty = 1'b0;
    slv_dat = '0;
    for (int k = 0; k < NUM_S; k++) begin
      if (mapped && dec_idx == DEC_W'(k)) begin
        slv_ack = s_ack_i[k];
        slv_err = s_err_i[k];
        slv_rty = s_rty_i[k];
        slv_dat = s_dat_i[k*DW +: DW];
      end
    end
  end

  assign slv_term = slv_ack | slv_err | slv_rty;

  // Strobe is withheld in the timeout cycle so the dead slave sees the beat end with the error.
  always_comb begin
    s_cyc_o = '0;
    s_stb_o = '0;
    s_we_o  = '0;
    for (int k = 0; k < NUM_S; k++) begin
      if (busy && mapped && bus_cyc && dec_idx == DEC_W'(k)) begin
        s_cyc_o[k] = 1'b1;
        s_stb_o[k] = bus_stb & ~to_fire;
        s_we_o[k]  = bus_we;
      end
    end
  end

  always_comb begin
    m_ack_o = '0;
    m_err_o = '0;
    m_rty_o = '0;
    m_dat_o = '0;
    for (int k = 0; k < NUM_M; k++) begin
      if (busy && g_oh[k]) begin
        m_ack_o[k]           = bus_cyc & slv_ack;
        m_err_o[k]           = (bus_cyc & slv_err) | err_q | to_fire;
        m_rty_o[k]           = bus_cyc & slv_rty;
        m_dat_o[k*DW +: DW]  = slv_dat;
      end
    end
  end

  // err_q only sets from 0, so a master still holding stb in the error cycle gets a single pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= ST_IDLE;
      g_oh   <= '0;
      rr_ptr <= '0;
      err_q  <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (arb_vld) begin
            state  <= ST_BUSY;
            g_oh   <= arb_gnt;
            rr_ptr <= rr_next;
          end
        end
        ST_BUSY: begin
          if (!bus_cyc) begin
            state <= ST_IDLE;
          end else if (bus_stb && !mapped && !err_q) begin
            err_q <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef WB_IC_TIMEOUT_EN
  logic [15:0] to_cnt;
  logic        to_wait;

  // Unmapped beats already terminate through err_q, so only mapped waits are timed.
  assign to_wait = busy && bus_cyc && bus_stb && mapped && !slv_term;
  assign to_fire = to_wait && (to_cnt == 16'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      to_cnt <= '0;
    end else if (!to_wait || to_fire) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + 16'd1;
    end
  end
`else
  assign to_fire = 1'b0;
`endif

endmodule

// File: tb/tb_wb_rr_interconnect.sv
// tb_wb_rr_interconnect: directed checks of arbitration, decode, error/timeout and async reset.
module tb_wb_rr_interconnect;

  localparam int NUM_M = 2;
  localparam int NUM_S = 6;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int DEC_W = 4;
  localparam int TIMEOUT_CYC = 8;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic [NUM_M-1:0]      m_cyc_i, m_stb_i, m_we_i;
  logic [NUM_M*AW-1:0]   m_adr_i;
  logic [NUM_M*DW-1:0]   m_dat_i;
  logic [NUM_M*DW/8-1:0] m_sel_i;
  logic [NUM_M*DW-1:0]   m_dat_o;
  logic [NUM_M-1:0]      m_ack_o, m_err_o, m_rty_o;
  logic [NUM_S-1:0]      s_cyc_o, s_stb_o, s_we_o;
  logic [AW-1:0]         s_adr_o;
  logic [DW-1:0]         s_dat_o;
  logic [DW/8-1:0]       s_sel_o;
  logic [NUM_S*DW-1:0]   s_dat_i;
  logic [NUM_S-1:0]      s_ack_i, s_err_i, s_rty_i;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  wb_rr_interconnect #(
    .NUM_M(NUM_M), .NUM_S(NUM_S), .AW(AW), .DW(DW), .DEC_W(DEC_W), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk), .rst(rst),
    .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
    .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i),
    .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_rty_o(m_rty_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    m_cyc_i = '0; m_stb_i = '0; m_we_i = '0;
    m_adr_i = '0; m_dat_i = '0; m_sel_i = '0;
    s_dat_i = '0; s_ack_i = '0; s_err_i = '0; s_rty_i = '0;

    // reset values
    #1;
    chk("rst_s_cyc", s_cyc_o, 0);
    chk("rst_s_stb", s_stb_o, 0);
    chk("rst_m_ack", m_ack_o, 0);
    chk("rst_m_err", m_err_o, 0);
    chk("rst_s_adr", s_adr_o, 0);
    chk("rst_state", dut.state, 0);
    chk("rst_rr_ptr", dut.rr_ptr, 0);

    // both masters request at reset release: m0 first
    m_cyc_i = 2'b11; m_stb_i = 2'b11;
    m_adr_i = {32'h5000_0004, 32'h1000_0000};
    m_sel_i = 8'hFF;
    #11 rst = 1'b1;
    #1;
    chk("arb_latency_s_cyc", s_cyc_o, 0);
    tick();
    chk("m0_grant_s_cyc", s_cyc_o, 6'b000010);
    chk("m0_grant_s_stb", s_stb_o, 6'b000010);
    chk("m0_grant_s_adr", s_adr_o, 32'h1000_0000);
    chk("m0_no_ack_yet", m_ack_o, 0);
    s_ack_i[1] = 1'b1; s_dat_i[1*DW +: DW] = 32'h1111_2222;
    #1;
    chk("m0_ack", m_ack_o, 2'b01);
    chk("m0_dat", m_dat_o, 64'h0000_0000_1111_2222);
    tick();
    s_ack_i = '0; m_cyc_i[0] = 1'b0; m_stb_i[0] = 1'b0;
    #1;
    chk("m0_release_s_cyc", s_cyc_o, 0);
    tick();
    chk("idle_gap_state", dut.state, 0);
    chk("idle_gap_s_cyc", s_cyc_o, 0);
    tick();
    // m1 read of slave 5, ack after 3 cycles
    chk("m1_grant_s_stb", s_stb_o, 6'b100000);
    chk("m1_grant_s_cyc", s_cyc_o, 6'b100000);
    chk("m1_grant_s_adr", s_adr_o, 32'h5000_0004);
    chk("m1_read_s_we", s_we_o, 0);
    chk("m1_rr_ptr", dut.rr_ptr, 0);
    tick();
    chk("m1_wait1_ack", m_ack_o, 0);
    tick();
    chk("m1_wait2_ack", m_ack_o, 0);
    tick();
    s_ack_i[5] = 1'b1; s_dat_i[5*DW +: DW] = 32'hDEAD_BEEF;
    #1;
    chk("m1_ack", m_ack_o, 2'b10);
    chk("m1_dat", m_dat_o, 64'hDEAD_BEEF_0000_0000);
    chk("m1_only_slave5", s_stb_o, 6'b100000);
    tick();
    s_ack_i = '0;
    #1;
    chk("m1_ack_single", m_ack_o, 0);
    m_cyc_i[1] = 1'b0; m_stb_i[1] = 1'b0;
    tick();

    // unmapped access: single registered err
    m_cyc_i[1] = 1'b1; m_stb_i[1] = 1'b1; m_adr_i[1*AW +: AW] = 32'hF000_0000;
    tick();
    chk("unmap_s_stb", s_stb_o, 0);
    chk("unmap_s_cyc", s_cyc_o, 0);
    chk("unmap_err_t0", m_err_o, 0);
    tick();
    chk("unmap_err_t1", m_err_o, 2'b10);
    tick();
    chk("unmap_err_t2", m_err_o, 0);
    m_cyc_i[1] = 1'b0; m_stb_i[1] = 1'b0;
    tick();

    // bus lock: m0 four beats while m1 waits
    m_cyc_i = 2'b11; m_stb_i = 2'b11; m_we_i = 2'b01;
    m_adr_i = {32'h3000_0000, 32'h2000_0000};
    m_dat_i = {32'h0, 32'h1234_5678};
    m_sel_i = 8'h0F;
    tick();
    chk("lock_s_cyc", s_cyc_o, 6'b000100);
    chk("lock_s_we", s_we_o, 6'b000100);
    chk("lock_s_dat", s_dat_o, 32'h1234_5678);
    chk("lock_s_sel", s_sel_o, 4'hF);
    for (int b = 0; b < 4; b++) begin
      s_ack_i[2] = 1'b1;
      #1;
      chk($sformatf("lock_beat%0d_ack", b), m_ack_o, 2'b01);
      chk($sformatf("lock_beat%0d_stb", b), s_stb_o, 6'b000100);
      tick();
      s_ack_i = '0; m_stb_i[0] = 1'b0;
      if (b == 3) m_cyc_i[0] = 1'b0;
      #1;
      chk($sformatf("lock_gap%0d_stb", b), s_stb_o, 0);
      chk($sformatf("lock_gap%0d_cyc", b), s_cyc_o, (b == 3) ? 6'b000000 : 6'b000100);
      tick();
      if (b < 3) m_stb_i[0] = 1'b1;
    end
    chk("lock_release_state", dut.state, 0);
    chk("lock_release_s_cyc", s_cyc_o, 0);
    tick();
    chk("m1_after_lock_stb", s_stb_o, 6'b001000);
    chk("m1_after_lock_adr", s_adr_o, 32'h3000_0000);
    s_ack_i[3] = 1'b1;
    #1;
    chk("m1_after_lock_ack", m_ack_o, 2'b10);
    tick();
    s_ack_i = '0; m_cyc_i = '0; m_stb_i = '0;
    tick();

    // reset during a slave-3 write by m0
    m_cyc_i[0] = 1'b1; m_stb_i[0] = 1'b1; m_we_i[0] = 1'b1;
    m_adr_i[0 +: AW] = 32'h3000_0010; m_dat_i[0 +: DW] = 32'hCAFE_F00D; m_sel_i[0 +: 4] = 4'h3;
    tick();
    chk("wr3_s_cyc", s_cyc_o, 6'b001000);
    chk("wr3_s_we", s_we_o, 6'b001000);
    chk("wr3_s_dat", s_dat_o, 32'hCAFE_F00D);
    chk("wr3_s_sel", s_sel_o, 4'h3);
    chk("wr3_rr_ptr", dut.rr_ptr, 1);
    #3 rst = 1'b0;
    #1;
    chk("arst_s_cyc", s_cyc_o, 0);
    chk("arst_s_stb", s_stb_o, 0);
    chk("arst_s_dat", s_dat_o, 0);
    chk("arst_state", dut.state, 0);
    chk("arst_rr_ptr", dut.rr_ptr, 0);
    m_cyc_i = '0; m_stb_i = '0; m_we_i = '0;
    #2 rst = 1'b1;
    tick();

    // silent slave 2
    m_cyc_i[0] = 1'b1; m_stb_i[0] = 1'b1; m_adr_i[0 +: AW] = 32'h2000_0000;
    tick();
    for (int c = 1; c < TIMEOUT_CYC; c++) begin
      chk($sformatf("silent_c%0d_err", c), m_err_o, 0);
      tick();
    end
`ifdef WB_IC_TIMEOUT_EN
    chk("timeout_err", m_err_o, 2'b01);
    chk("timeout_stb_low", s_stb_o, 0);
    tick();
    chk("timeout_err_single", m_err_o, 0);
    chk("timeout_stb_back", s_stb_o, 6'b000100);
    chk("timeout_cnt_clear", dut.to_cnt, 0);
`else
    chk("no_timeout_err", m_err_o, 0);
    chk("no_timeout_stb", s_stb_o, 6'b000100);
    repeat (4) tick();
    chk("stall_err", m_err_o, 0);
    chk("stall_stb", s_stb_o, 6'b000100);
`endif
    m_cyc_i = '0; m_stb_i = '0;
    tick();
    tick();
    chk("end_state", dut.state, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_rr_interconnect.md
# wb_rr_interconnect

Parametrised Wishbone shared-bus interconnect that replaces the fixed 8-master/16-slave crossbar in the minimal SoC. It arbitrates NUM_M masters (CPU instruction and data ports, future DMA) round-robin onto one shared bus and decodes the top address bits to NUM_S slaves. It adds two behaviours the fixed crossbar lacks. First, it returns an error for unmapped addresses. Second, it applies a configurable no-acknowledge timeout, so a dead slave can no longer hang the core.

## Interface
Parameters:
- NUM_M, 2: number of masters (1..8).
- NUM_S, 6: number of slaves (1..16).
- AW, 32: address width.
- DW, 32: data width; select width is DW/8.
- DEC_W, 4: width of the slave index field, taken from addr[AW-1 -: DEC_W].
- TIMEOUT_CYC, 255: wait cycles without ack before the error is raised (1..65535).

Ports (vectors flattened, master/slave k at slice k):
- clk  input  1  bus clock.
- rst  input  1  reset; asynchronous, active-low.
- m_cyc_i, m_stb_i, m_we_i  input  NUM_M each  per-master Wishbone controls.
- m_adr_i  input  NUM_M*AW  master addresses.
- m_dat_i  input  NUM_M*DW  master write data.
- m_sel_i  input  NUM_M*DW/8  byte selects.
- m_dat_o  output  NUM_M*DW  read data; valid only on the granted slice.
- m_ack_o, m_err_o, m_rty_o  output  NUM_M each  terminations.
- s_cyc_o, s_stb_o, s_we_o  output  NUM_S each  per-slave controls.
- s_adr_o  output  AW  shared slave address.
- s_dat_o  output  DW  shared slave write data.
- s_sel_o  output  DW/8  shared slave byte selects.
- s_dat_i  input  NUM_S*DW  slave read data.
- s_ack_i, s_err_i, s_rty_i  input  NUM_S each  slave terminations.

## Operation
- FSM states:
  - IDLE: no grant.
  - BUSY: grant g locked to one master.
- IDLE → BUSY: at the first edge where any m_cyc_i is high. The winner is the first requester at or after rr_ptr, searching upward with wrap. After the grant, rr_ptr = (g+1) mod NUM_M.
- BUSY → IDLE: at the edge where m_cyc_i[g] is low. The grant is held across multiple stb beats while cyc stays high (bus lock).
- Decode: idx = m_adr_i[g] top DEC_W bits. The access is mapped when idx < NUM_S.
- Mapped access: s_cyc_o[idx] and s_stb_o[idx] follow the master combinationally. The slave's ack, err, rty and dat are routed back to master g.
- Unmapped access: no slave strobed. m_err_o[g] is a registered single-cycle pulse one cycle after stb is seen.
- Error pulse rule: the error register is set only when it is currently 0. This guarantees exactly one err per beat even though the master keeps stb high for one more cycle.
- Non-granted masters: m_ack_o, m_err_o, m_rty_o = 0 and m_dat_o = 0.
- Shared address, data and select outputs carry master g in BUSY and 0 in IDLE.

## Timing
- Reset values:
  - state = IDLE, rr_ptr = 0, timeout counter = 0, error register = 0.
  - All s_cyc_o/s_stb_o/s_we_o = 0.
  - All m_ack_o/m_err_o/m_rty_o = 0; all data and address outputs = 0.
- Arbitration latency: 1 cycle. A request at cycle t reaches the slave at cycle t+1.
- Re-arbitration after release: the FSM returns to IDLE, so at least one idle cycle separates grants.
- Slave ack/err/rty propagate combinationally: zero added latency once granted.
- Simultaneous requests: resolved by rr_ptr, so no master waits more than NUM_M-1 grants.
- Reset asserted mid-transfer: all outputs go to reset values immediately (asynchronous). The in-flight beat is abandoned without a termination.

## Configuration
- WB_IC_TIMEOUT_EN defined:
  - A 16-bit counter increments each BUSY cycle with stb high and no slave ack/err/rty; it clears on any termination and on leaving BUSY.
  - When the count reaches TIMEOUT_CYC, m_err_o[g] pulses for 1 cycle and s_stb_o is forced low for that cycle.
- Undefined: no counter. Only unmapped addresses generate err, and a silent slave stalls the bus indefinitely.

## Structure
- Package wb_ic_pkg holds the state encoding (IDLE=0, BUSY=1), the clog2 function and the decode-index helper.
- One sub-module, wb_rr_arbiter: request vector and rr_ptr in, one-hot grant plus index out; purely combinational, parametrised by NUM_M.

## Test plan
- Masters 0 and 1 both assert cyc at reset release → m0 granted first. After m0 drops cyc, m1 granted with exactly 1 idle cycle between the grants.
- m1 reads 0x5000_0004; slave 5 acks after 3 cycles with 0xDEAD_BEEF → m_dat_o[1] = 0xDEAD_BEEF with m_ack_o[1] high for 1 cycle; s_stb_o[5] is the only slave strobe.
- Access to 0xF000_0000 with NUM_S=6 → no s_stb_o asserted; m_err_o pulses exactly 1 cycle, one cycle after stb.
- With WB_IC_TIMEOUT_EN and TIMEOUT_CYC=8, slave 2 never acks → m_err_o pulses at cycle 8 of stb; counter clears afterwards.
- m0 holds cyc across 4 stb beats while m1 requests → m1 blocked until m0 releases cyc; no interleaving.
- Reset pulled low during an active slave-3 write → s_cyc_o/s_stb_o drop to 0 immediately; after release, state is IDLE and rr_ptr = 0.
